array_op_sequencer: RTL and testbench

//  Command-level sequencer for one 1k-cell array operation (SET / RESET / READ).

---
 rtl/array_op_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_array_op_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/array_op_sequencer.sv
// Command sequencer for one SET/RESET/READ cell operation: BL launch, WL pulse timing, completion.
// Optional WAIT_BL watchdog is compiled in when the SEQ_TIMEOUT_EN macro is defined.
module array_op_sequencer #(
    parameter logic [7:0] PULSE_W = 8'd20
`ifdef SEQ_TIMEOUT_EN
    ,
    parameter logic [7:0] TIMEOUT = 8'd255
`endif
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic        cmd_set,
    input  logic [9:0]  cmd_addr,
    output logic        bl_work_en,
    output logic        bl_work_mode,
    output logic        bl_op_mode,
    output logic [4:0]  bl_addr_hi,
    input  logic        bl_assert_en,
    output logic        bl_op_down,
    output logic [4:0]  wl_addr,
    output logic        wl_pulse_en,
    output logic        rd_sample_en,
    output logic        busy,
    output logic        done_pulse,
    output logic        err_timeout,
    output logic [15:0] op_cnt
);

    typedef enum logic [2:0] {StIdle, StLaunch, StWaitBl, StPulse, StDone} state_e;

    localparam logic [7:0] PulseLen = (PULSE_W == 8'd0) ? 8'd1 : PULSE_W;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic        set_q, set_d;
    logic [4:0]  addr_hi_q, addr_hi_d;
    logic [4:0]  wl_addr_q, wl_addr_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        busy_q, busy_d;
    logic        work_en_q, work_en_d;
    logic        op_down_q, op_down_d;
    logic        wl_pulse_q, wl_pulse_d;
    logic        rd_sample_q, rd_sample_d;
    logic        done_q, done_d;
    logic [15:0] op_cnt_q, op_cnt_d;
`ifdef SEQ_TIMEOUT_EN
    logic [7:0]  wd_q, wd_d;
    logic        err_q, err_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        set_d       = set_q;
        addr_hi_d   = addr_hi_q;
        wl_addr_d   = wl_addr_q;
        cmd_ready_d = cmd_ready_q;
        wl_pulse_d  = wl_pulse_q;
        op_cnt_d    = op_cnt_q;
        work_en_d   = 1'b0;
        op_down_d   = 1'b0;
        rd_sample_d = 1'b0;
        done_d      = 1'b0;
`ifdef SEQ_TIMEOUT_EN
        wd_d        = wd_q;
        err_d       = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready_q) begin
                    write_d     = cmd_write;
                    set_d       = cmd_set;
                    addr_hi_d   = cmd_addr[9:5];
                    wl_addr_d   = cmd_addr[4:0];
                    work_en_d   = 1'b1;
                    cmd_ready_d = 1'b0;
                    state_d     = StLaunch;
                end
            end
            StLaunch: begin
`ifdef SEQ_TIMEOUT_EN
                wd_d    = TIMEOUT;
`endif
                state_d = StWaitBl;
            end
            StWaitBl: begin
                // A late bl_assert_en on the expiry cycle still takes the normal path.
                if (bl_assert_en) begin
                    cnt_d      = PulseLen;
                    wl_pulse_d = 1'b1;
                    state_d    = StPulse;
                    if (PulseLen == 8'd1) begin
                        op_down_d   = 1'b1;
                        rd_sample_d = ~write_q;
                    end
                end
`ifdef SEQ_TIMEOUT_EN
                else if (wd_q == 8'd1) begin
                    err_d       = 1'b1;
                    op_down_d   = 1'b1;
                    cmd_ready_d = 1'b1;
                    state_d     = StIdle;
                end else begin
                    wd_d = wd_q - 8'd1;
                end
`endif
            end
            StPulse: begin
                if (cnt_q == 8'd1) begin
                    wl_pulse_d = 1'b0;
                    done_d     = 1'b1;
                    op_cnt_d   = op_cnt_q + 16'd1;
                    state_d    = StDone;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                    // Strobes are registered, so raise them one cycle ahead of the last pulse cycle.
                    if (cnt_q == 8'd2) begin
                        op_down_d   = 1'b1;
                        rd_sample_d = ~write_q;
                    end
                end
            end
            StDone: begin
                cmd_ready_d = 1'b1;
                state_d     = StIdle;
            end
            default: begin
                cmd_ready_d = 1'b1;
                wl_pulse_d  = 1'b0;
                state_d     = StIdle;
            end
        endcase
        busy_d = ~cmd_ready_d;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= StIdle;
            cnt_q       <= 8'd0;
            write_q     <= 1'b0;
            set_q       <= 1'b0;
            addr_hi_q   <= 5'd0;
            wl_addr_q   <= 5'd0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            work_en_q   <= 1'b0;
            op_down_q   <= 1'b0;
            wl_pulse_q  <= 1'b0;
            rd_sample_q <= 1'b0;
            done_q      <= 1'b0;
            op_cnt_q    <= 16'd0;
`ifdef SEQ_TIMEOUT_EN
            wd_q        <= 8'd0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            set_q       <= set_d;
            addr_hi_q   <= addr_hi_d;
            wl_addr_q   <= wl_addr_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            work_en_q   <= work_en_d;
            op_down_q   <= op_down_d;
            wl_pulse_q  <= wl_pulse_d;
            rd_sample_q <= rd_sample_d;
            done_q      <= done_d;
            op_cnt_q    <= op_cnt_d;
`ifdef SEQ_TIMEOUT_EN
            wd_q        <= wd_d;
            err_q       <= err_d;
`endif
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign busy         = busy_q;
    assign bl_work_en   = work_en_q;
    assign bl_work_mode = write_q;
    assign bl_op_mode   = set_q;
    assign bl_addr_hi   = addr_hi_q;
    assign wl_addr      = wl_addr_q;
    assign bl_op_down   = op_down_q;
    assign wl_pulse_en  = wl_pulse_q;
    assign rd_sample_en = rd_sample_q;
    assign done_pulse   = done_q;
    assign op_cnt       = op_cnt_q;
`ifdef SEQ_TIMEOUT_EN
    assign err_timeout  = err_q;
`else
    assign err_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_array_op_sequencer.sv
// Bench for array_op_sequencer: instance 0 uses PULSE_W=20, instance 1 uses PULSE_W=0.
// With SEQ_TIMEOUT_EN defined, a third instance (TIMEOUT=8) exercises the watchdog.
module tb_array_op_sequencer;

    logic sys_clk = 1'b0;
    logic sys_rst;
    always #5 sys_clk = ~sys_clk;

    logic [1:0]       cmd_valid, cmd_write, cmd_set, bl_assert_en;
    logic [1:0][9:0]  cmd_addr;
    wire  [1:0]       cmd_ready, bl_work_en, bl_work_mode, bl_op_mode, bl_op_down;
    wire  [1:0]       wl_pulse_en, rd_sample_en, busy, done_pulse, err_timeout;
    wire  [1:0][4:0]  bl_addr_hi, wl_addr;
    wire  [1:0][15:0] op_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0]  hi;
        logic [4:0]  wl;
        logic        mode;
        logic        opm;
        logic [15:0] cnt;
    } sb_t;
    sb_t sbq0[$];
    sb_t sbq1[$];
    logic [15:0] push_cnt [2];

    typedef struct {
        int         inst;
        logic       w;
        logic       s;
        logic [9:0] addr;
        int         dly;
        logic [4:0] hi;
        logic [4:0] wl;
    } vec_t;
    vec_t vecs[7];

`ifdef SEQ_TIMEOUT_EN
    localparam int LongDly = 200;
`else
    localparam int LongDly = 300;
`endif

    array_op_sequencer #(.PULSE_W(8'd20)) dut_a (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_write(cmd_write[0]),
        .cmd_set(cmd_set[0]), .cmd_addr(cmd_addr[0]),
        .bl_work_en(bl_work_en[0]), .bl_work_mode(bl_work_mode[0]), .bl_op_mode(bl_op_mode[0]),
        .bl_addr_hi(bl_addr_hi[0]), .bl_assert_en(bl_assert_en[0]), .bl_op_down(bl_op_down[0]),
        .wl_addr(wl_addr[0]), .wl_pulse_en(wl_pulse_en[0]), .rd_sample_en(rd_sample_en[0]),
        .busy(busy[0]), .done_pulse(done_pulse[0]), .err_timeout(err_timeout[0]),
        .op_cnt(op_cnt[0])
    );

    array_op_sequencer #(.PULSE_W(8'd0)) dut_b (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_write(cmd_write[1]),
        .cmd_set(cmd_set[1]), .cmd_addr(cmd_addr[1]),
        .bl_work_en(bl_work_en[1]), .bl_work_mode(bl_work_mode[1]), .bl_op_mode(bl_op_mode[1]),
        .bl_addr_hi(bl_addr_hi[1]), .bl_assert_en(bl_assert_en[1]), .bl_op_down(bl_op_down[1]),
        .wl_addr(wl_addr[1]), .wl_pulse_en(wl_pulse_en[1]), .rd_sample_en(rd_sample_en[1]),
        .busy(busy[1]), .done_pulse(done_pulse[1]), .err_timeout(err_timeout[1]),
        .op_cnt(op_cnt[1])
    );

`ifdef SEQ_TIMEOUT_EN
    logic        t_valid, t_write, t_set, t_assert;
    logic [9:0]  t_addr;
    wire         t_ready, t_work_en, t_mode, t_opm, t_op_down, t_wl, t_rd, t_busy, t_done, t_err;
    wire  [4:0]  t_hi, t_wla;
    wire  [15:0] t_cnt;

    array_op_sequencer #(.PULSE_W(8'd3), .TIMEOUT(8'd8)) dut_t (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .cmd_valid(t_valid), .cmd_ready(t_ready), .cmd_write(t_write), .cmd_set(t_set),
        .cmd_addr(t_addr), .bl_work_en(t_work_en), .bl_work_mode(t_mode), .bl_op_mode(t_opm),
        .bl_addr_hi(t_hi), .bl_assert_en(t_assert), .bl_op_down(t_op_down), .wl_addr(t_wla),
        .wl_pulse_en(t_wl), .rd_sample_en(t_rd), .busy(t_busy), .done_pulse(t_done),
        .err_timeout(t_err), .op_cnt(t_cnt)
    );
`endif

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    function automatic logic [19:0] outs(input int i);
        return {cmd_ready[i], busy[i], bl_work_en[i], bl_work_mode[i], bl_op_mode[i],
                bl_addr_hi[i], bl_op_down[i], wl_addr[i], wl_pulse_en[i], rd_sample_en[i],
                done_pulse[i], err_timeout[i]};
    endfunction

    task automatic sb_check(input int i, input string tag);
        sb_t e;
        if ((i == 0 && sbq0.size() == 0) || (i == 1 && sbq1.size() == 0)) begin
            chk({tag, "_sb_nonempty"}, 0, 1);
        end else begin
            e = (i == 0) ? sbq0.pop_front() : sbq1.pop_front();
            chk({tag, "_op_cnt"}, int'(op_cnt[i]), int'(e.cnt));
            chk({tag, "_bl_addr_hi"}, int'(bl_addr_hi[i]), int'(e.hi));
            chk({tag, "_wl_addr"}, int'(wl_addr[i]), int'(e.wl));
            chk({tag, "_modes"}, int'({bl_work_mode[i], bl_op_mode[i]}), int'({e.mode, e.opm}));
        end
    endtask

    task automatic sb_push(input int i, input logic w, input logic s,
                           input logic [4:0] hi, input logic [4:0] wl);
        sb_t e;
        push_cnt[i] = push_cnt[i] + 16'd1;
        e.hi = hi; e.wl = wl; e.mode = w; e.opm = s; e.cnt = push_cnt[i];
        if (i == 0) sbq0.push_back(e);
        else sbq1.push_back(e);
    endtask

    // One complete operation; BL model asserts dly cycles after the bl_work_en cycle.
    task automatic do_op(input int i, input logic w, input logic s, input logic [9:0] a,
                         input int dly, input int pw, input logic [4:0] ehi,
                         input logic [4:0] ewl, input string tag);
        int t, n_wl, od_at, rd_at, done_at, first_wl, stray, early;
        t = 0;
        while (cmd_ready[i] !== 1'b1 && t < 100) begin
            @(negedge sys_clk);
            t++;
        end
        chk({tag, "_ready"}, int'(cmd_ready[i]), 1);
        cmd_valid[i] = 1'b1; cmd_write[i] = w; cmd_set[i] = s; cmd_addr[i] = a;
        sb_push(i, w, s, ehi, ewl);
        @(negedge sys_clk);
        // Scramble the inputs so the bench sees whether the DUT really latched them.
        cmd_valid[i] = 1'b0; cmd_write[i] = ~w; cmd_set[i] = ~s; cmd_addr[i] = ~a;
        chk({tag, "_work_en"}, int'(bl_work_en[i]), 1);
        early = 0;
        repeat (dly) begin
            @(negedge sys_clk);
            if (wl_pulse_en[i] || err_timeout[i] || bl_work_en[i] || !busy[i]) early++;
        end
        bl_assert_en[i] = 1'b1;
        chk({tag, "_wait_quiet"}, early, 0);
        n_wl = 0; od_at = -1; rd_at = -1; done_at = -1; first_wl = 0; stray = 0;
        for (int c = 0; c < pw + 10 && done_at < 0; c++) begin
            @(negedge sys_clk);
            bl_assert_en[i] = (c == 1);  // spurious assert outside WAIT_BL must be ignored
            if (c == 0) first_wl = int'(wl_pulse_en[i]);
            if (wl_pulse_en[i]) begin
                n_wl++;
                if (bl_op_down[i] && od_at < 0) od_at = n_wl;
                if (rd_sample_en[i] && rd_at < 0) rd_at = n_wl;
            end else if (bl_op_down[i] || rd_sample_en[i] || err_timeout[i]) begin
                stray++;
            end
            if (done_pulse[i]) begin
                done_at = c;
                sb_check(i, tag);
            end
        end
        bl_assert_en[i] = 1'b0;
        chk({tag, "_wl_first"}, first_wl, 1);
        chk({tag, "_wl_len"}, n_wl, pw);
        chk({tag, "_op_down_at"}, od_at, pw);
        chk({tag, "_rd_sample_at"}, rd_at, w ? -1 : pw);
        chk({tag, "_stray"}, stray, 0);
        chk({tag, "_done_at"}, done_at, pw);
        @(negedge sys_clk);
        chk({tag, "_ready_after"}, int'({cmd_ready[i], busy[i], done_pulse[i]}), 4);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int n, t, stray, acc, dn, idle_gap, bad_busy, pend, drop, extra;
        vecs[0] = '{0, 1'b1, 1'b1, 10'h3A5, 21, 5'h1D, 5'h05};
        vecs[1] = '{1, 1'b0, 1'b0, 10'h000, 1, 5'h00, 5'h00};
        vecs[2] = '{0, 1'b1, 1'b0, 10'h3FF, 3, 5'h1F, 5'h1F};
        vecs[3] = '{0, 1'b0, 1'b1, 10'h021, 1, 5'h01, 5'h01};
        vecs[4] = '{1, 1'b1, 1'b0, 10'h155, 2, 5'h0A, 5'h15};
        vecs[5] = '{1, 1'b0, 1'b1, 10'h2E3, 5, 5'h17, 5'h03};
        vecs[6] = '{0, 1'b1, 1'b1, 10'h1C0, LongDly, 5'h0E, 5'h00};

        sys_rst = 1'b1;
        cmd_valid = '0; cmd_write = '0; cmd_set = '0; cmd_addr = '0; bl_assert_en = '0;
        push_cnt[0] = 16'd0; push_cnt[1] = 16'd0;
`ifdef SEQ_TIMEOUT_EN
        t_valid = 1'b0; t_write = 1'b0; t_set = 1'b0; t_addr = '0; t_assert = 1'b0;
`endif
        repeat (3) @(negedge sys_clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_outs", int'(outs(i)), 32'h80000);
            chk("rst_op_cnt", int'(op_cnt[i]), 0);
        end
        sys_rst = 1'b0;
        @(negedge sys_clk);

        // Reset during the 5th WL pulse cycle aborts the operation.
        cmd_valid[0] = 1'b1; cmd_write[0] = 1'b1; cmd_set[0] = 1'b0; cmd_addr[0] = 10'h0F0;
        @(negedge sys_clk);
        cmd_valid[0] = 1'b0;
        repeat (3) @(negedge sys_clk);
        bl_assert_en[0] = 1'b1;
        @(negedge sys_clk);
        bl_assert_en[0] = 1'b0;
        n = 0;
        for (int c = 0; c < 50; c++) begin
            if (wl_pulse_en[0]) n++;
            if (n == 5) break;
            @(negedge sys_clk);
        end
        chk("abort_wl_cycles", n, 5);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        chk("abort_outs", int'(outs(0)), 32'h80000);
        chk("abort_op_cnt", int'(op_cnt[0]), 0);
        stray = 0;
        repeat (30) begin
            @(negedge sys_clk);
            if (done_pulse[0] || wl_pulse_en[0] || bl_op_down[0] || !cmd_ready[0]) stray++;
        end
        chk("abort_quiet", stray, 0);

        for (int v = 0; v < 7; v++) begin
            do_op(vecs[v].inst, vecs[v].w, vecs[v].s, vecs[v].addr, vecs[v].dly,
                  (vecs[v].inst == 0) ? 20 : 1, vecs[v].hi, vecs[v].wl,
                  $sformatf("vec%0d", v));
        end

        // cmd_valid held high: three back-to-back reads on the PULSE_W=0 instance.
        cmd_valid[1] = 1'b1; cmd_write[1] = 1'b0; cmd_set[1] = 1'b0; cmd_addr[1] = 10'h2AA;
        acc = 0; dn = 0; idle_gap = 0; bad_busy = 0; pend = 0; drop = 0;
        for (int c = 0; c < 200 && dn < 3; c++) begin
            if (drop != 0) cmd_valid[1] = 1'b0;
            if (busy[1] === cmd_ready[1]) bad_busy++;
            if (done_pulse[1]) begin
                dn++;
                sb_check(1, "b2b");
            end
            if (cmd_ready[1]) begin
                if (acc > 0) idle_gap++;
                if (cmd_valid[1]) begin
                    acc++;
                    sb_push(1, 1'b0, 1'b0, 5'h15, 5'h0A);
                    if (acc == 3) drop = 1;
                end
            end
            bl_assert_en[1] = pend[0];
            pend = int'(bl_work_en[1]);
            @(negedge sys_clk);
        end
        bl_assert_en[1] = 1'b0;
        extra = 0;
        repeat (10) begin
            @(negedge sys_clk);
            if (bl_work_en[1] || !cmd_ready[1]) extra++;
        end
        chk("b2b_accepts", acc, 3);
        chk("b2b_dones", dn, 3);
        chk("b2b_idle_gaps", idle_gap, 2);
        chk("b2b_busy_vs_ready", bad_busy, 0);
        chk("b2b_no_extra", extra, 0);
        chk("b2b_final_cnt", int'(op_cnt[1]), 6);
        chk("a_final_cnt", int'(op_cnt[0]), 4);

`ifdef SEQ_TIMEOUT_EN
        begin
            int err_at, od_at, wl_seen, done_seen, rdy_at_err;
            t_valid = 1'b1; t_write = 1'b1; t_set = 1'b1; t_addr = 10'h123;
            @(negedge sys_clk);
            t_valid = 1'b0;
            chk("to_work_en", int'(t_work_en), 1);
            err_at = -1; od_at = -1; wl_seen = 0; done_seen = 0; rdy_at_err = -1;
            for (int c = 1; c <= 20; c++) begin
                @(negedge sys_clk);
                if (t_err && err_at < 0) begin
                    err_at = c;
                    rdy_at_err = int'(t_ready);
                end
                if (t_op_down && od_at < 0) od_at = c;
                if (t_wl) wl_seen++;
                if (t_done) done_seen++;
            end
            chk("to_err_at", err_at, 9);
            chk("to_op_down_at", od_at, 9);
            chk("to_ready_at_err", rdy_at_err, 1);
            chk("to_no_wl", wl_seen, 0);
            chk("to_no_done", done_seen, 0);
            chk("to_op_cnt", int'(t_cnt), 0);

            // bl_assert_en on the expiry cycle takes the normal path.
            t_valid = 1'b1;
            @(negedge sys_clk);
            t_valid = 1'b0;
            repeat (8) @(negedge sys_clk);
            t_assert = 1'b1;
            @(negedge sys_clk);
            t_assert = 1'b0;
            wl_seen = 0; done_seen = 0; err_at = -1;
            for (int c = 0; c < 10; c++) begin
                if (t_wl) wl_seen++;
                if (t_err) err_at = c;
                if (t_done && done_seen == 0) begin
                    done_seen = 1;
                    chk("to_late_op_cnt", int'(t_cnt), 1);
                end
                @(negedge sys_clk);
            end
            chk("to_late_wl_len", wl_seen, 3);
            chk("to_late_no_err", err_at, -1);
            chk("to_late_done", done_seen, 1);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
